// File: rtl/reg_wr_arb.sv
// Two-source register write arbiter: per-source FIFOs feeding one registered output port.
// Define REG_WR_ARB_PRIO_EN for fixed priority (source 0 first); default is round-robin.
module reg_wr_arb #(
  parameter int AWIDTH     = 8,
  parameter int DWIDTH     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              reg_clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] s0_wr_addr,
  input  logic [DWIDTH-1:0] s0_wr_data,
  input  logic              s0_wr_en,
  input  logic [AWIDTH-1:0] s1_wr_addr,
  input  logic [DWIDTH-1:0] s1_wr_data,
  input  logic              s1_wr_en,
  output logic [AWIDTH-1:0] m_wr_addr,
  output logic [DWIDTH-1:0] m_wr_data,
  output logic              m_wr_valid,
  input  logic              m_wr_ready,
  output logic              m_wr_src,
  output logic              s0_ovf,
  output logic              s1_ovf,
  input  logic              ovf_clr
);

  localparam int IW = $clog2(FIFO_DEPTH);
  localparam int PW = IW + 1;
  localparam int EW = AWIDTH + DWIDTH;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_OUT = 1'b1} state_t;

  logic [EW-1:0]     mem0_q [FIFO_DEPTH];
  logic [EW-1:0]     mem1_q [FIFO_DEPTH];
  logic [PW-1:0]     wr0_q, rd0_q, wr1_q, rd1_q;
  logic [PW-1:0]     wr0_d, rd0_d, wr1_d, rd1_d;
  state_t            state_q;
  logic              valid_q, src_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] data_q;
  logic              ovf0_q, ovf1_q, ovf0_d, ovf1_d;
`ifndef REG_WR_ARB_PRIO_EN
  logic              last_q;
`endif

  logic          empty0_s, empty1_s, full0_s, full1_s;
  logic          can_load_s, load_s, grant1_s;
  logic          pop0_s, pop1_s, push0_s, push1_s;
  logic          ovf0_set_s, ovf1_set_s;
  logic [EW-1:0] head_s;

  assign empty0_s = (wr0_q == rd0_q);
  assign empty1_s = (wr1_q == rd1_q);
  assign full0_s  = (wr0_q[IW] != rd0_q[IW]) && (wr0_q[IW-1:0] == rd0_q[IW-1:0]);
  assign full1_s  = (wr1_q[IW] != rd1_q[IW]) && (wr1_q[IW-1:0] == rd1_q[IW-1:0]);

  // A new word may enter the output register when it is empty or being consumed this edge.
  assign can_load_s = (state_q == S_IDLE) || m_wr_ready;
  assign load_s     = can_load_s && !(empty0_s && empty1_s);

  always_comb begin
    grant1_s = 1'b0;
`ifdef REG_WR_ARB_PRIO_EN
    grant1_s = empty0_s;
`else
    if (!empty0_s && !empty1_s) begin
      grant1_s = ~last_q;
    end else begin
      grant1_s = empty0_s;
    end
`endif
  end

  assign pop0_s     = load_s && !grant1_s;
  assign pop1_s     = load_s && grant1_s;
  assign push0_s    = s0_wr_en && (!full0_s || pop0_s);
  assign push1_s    = s1_wr_en && (!full1_s || pop1_s);
  assign ovf0_set_s = s0_wr_en && full0_s && !pop0_s;
  assign ovf1_set_s = s1_wr_en && full1_s && !pop1_s;
  assign head_s     = grant1_s ? mem1_q[rd1_q[IW-1:0]] : mem0_q[rd0_q[IW-1:0]];

  always_comb begin
    wr0_d = push0_s ? wr0_q + PW'(1) : wr0_q;
    wr1_d = push1_s ? wr1_q + PW'(1) : wr1_q;
    rd0_d = pop0_s  ? rd0_q + PW'(1) : rd0_q;
    rd1_d = pop1_s  ? rd1_q + PW'(1) : rd1_q;
    // A fresh overflow wins over a coincident clear.
    if (ovf0_set_s) begin
      ovf0_d = 1'b1;
    end else begin
      ovf0_d = ovf0_q && !ovf_clr;
    end
    if (ovf1_set_s) begin
      ovf1_d = 1'b1;
    end else begin
      ovf1_d = ovf1_q && !ovf_clr;
    end
  end

  always_ff @(posedge reg_clk) begin
    if (push0_s) begin
      mem0_q[wr0_q[IW-1:0]] <= {s0_wr_addr, s0_wr_data};
    end
    if (push1_s) begin
      mem1_q[wr1_q[IW-1:0]] <= {s1_wr_addr, s1_wr_data};
    end
  end

  always_ff @(posedge reg_clk or posedge rst) begin
    if (rst) begin
      wr0_q  <= '0;
      rd0_q  <= '0;
      wr1_q  <= '0;
      rd1_q  <= '0;
      ovf0_q <= 1'b0;
      ovf1_q <= 1'b0;
    end else begin
      wr0_q  <= wr0_d;
      rd0_q  <= rd0_d;
      wr1_q  <= wr1_d;
      rd1_q  <= rd1_d;
      ovf0_q <= ovf0_d;
      ovf1_q <= ovf1_d;
    end
  end

  always_ff @(posedge reg_clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      src_q   <= 1'b0;
`ifndef REG_WR_ARB_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_s) begin
            state_q <= S_OUT;
            valid_q <= 1'b1;
            addr_q  <= head_s[EW-1:DWIDTH];
            data_q  <= head_s[DWIDTH-1:0];
            src_q   <= grant1_s;
`ifndef REG_WR_ARB_PRIO_EN
            last_q  <= grant1_s;
`endif
          end
        end
        S_OUT: begin
          if (m_wr_ready) begin
            if (load_s) begin
              addr_q  <= head_s[EW-1:DWIDTH];
              data_q  <= head_s[DWIDTH-1:0];
              src_q   <= grant1_s;
`ifndef REG_WR_ARB_PRIO_EN
              last_q  <= grant1_s;
`endif
            end else begin
              state_q <= S_IDLE;
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign m_wr_addr  = addr_q;
  assign m_wr_data  = data_q;
  assign m_wr_valid = valid_q;
  assign m_wr_src   = src_q;
  assign s0_ovf     = ovf0_q;
  assign s1_ovf     = ovf1_q;

endmodule
